button_press_decoder: RTL
=========================

// Module: button_press_decoder
//
// PURPOSE
//  Upstream front end for the board push-button. Synchronises and debounces the
//  raw active-low pin, then classifies each press as short or long.
//  Produces one-cycle event pulses plus an active-low reset request that the
//  application logic uses as its asynchronous reset (counter, LED register).
//  Runs on the OSCH clock.
//
// PARAMETERS
//  DEBOUNCE  16  log2 of cycles the synced pin must differ from the stable level before acceptance
//  LONG      27  log2 of cycles a debounced press must last to count as long (~1 s at 133 MHz)
//
// PORTS
//  clock       in   1  system clock (OSCH output)
//  resetn      in   1  asynchronous active-low reset (power-on)
//  signal_pin  in   1  raw button pin, asynchronous, low = pressed
//  pressed     out  1  debounced level, 1 = pressed
//  short_press out  1  one-cycle pulse on release of a press shorter than 2^LONG cycles
//  long_press  out  1  one-cycle pulse when a press reaches 2^LONG cycles (button still held)
//  signal      out  1  active-low reset request; 0 while in LONG_HELD
//
// BEHAVIOUR
//  - Reset (async, resetn=0):
//    - Sync flops = 1 (released); stable level = released; counters = 0; state = IDLE.
//    - pressed=0, short_press=0, long_press=0, signal=1.
//  - Synchroniser: 2 flops on signal_pin; no logic between them.
//  - Debounce: DEBOUNCE-bit counter.
//    - Clears whenever synced == stable.
//    - Otherwise increments.
//    - In the cycle it is all-ones and synced still differs: stable <= synced, counter <= 0.
//    - Any glitch back to the stable level restarts the count.
//    - Pin-to-pressed latency = 2 + 2^DEBOUNCE cycles.
//  - FSM, driven by the debounced level; all outputs registered:
//    - IDLE:      press edge -> PRESSED, hold counter <= 0.
//    - PRESSED:   hold counter (LONG bits) increments each cycle.
//        - Release -> IDLE, short_press=1 for 1 cycle.
//        - Hold counter all-ones while still pressed -> LONG_HELD, long_press=1 for 1 cycle.
//    - LONG_HELD: signal=0; hold counter frozen.
//        - Release -> IDLE, no short_press, signal=1 the following cycle.
//  - Simultaneous release and terminal count in the same cycle: release wins.
//    short_press fires; long_press does not.
//  - Hold counter never wraps; it is only used in PRESSED.
//  - short_press and long_press are never both 1.
//  - Reset mid-operation aborts everything.
//    - A button held through reset release must be re-debounced.
//    - It is then timed as a fresh press.
//  - No metastability path: FSM sees only the debounced level.
//
// STRUCTURE
//  - Sub-module debounce_filter (params DEBOUNCE).
//    - Ports: clock, resetn, signal_pin -> level (1 = pressed).
//    - Contains the 2-flop synchroniser and the debounce counter; reused for other pins.
//  - Top holds the FSM, hold counter and output registers.
//  - Shared include button_defs.vh:
//    - 2-bit state encodings IDLE=0, PRESSED=1, LONG_HELD=2.
//    - Default DEBOUNCE/LONG constants.
//  - Unused encoding 3 recovers to IDLE.
//
// TESTING (bench uses DEBOUNCE=3, LONG=6)
//  1. Reset: resetn=0 with pin=0.
//     -> all outputs at reset values; after resetn=1, pressed=1 exactly 2+8 cycles later.
//  2. Bounce: pin low for 5 cycles, high 1, low 5.
//     -> pressed stays 0; a further 8-cycle low run sets pressed=1.
//  3. Short press: pin low 30 cycles then high.
//     -> one short_press pulse 10 cycles after release edge; long_press never 1.
//  4. Long press: pin low 100 cycles.
//     -> long_press pulse 64 cycles after pressed rises.
//     -> signal=0 from then until 1 cycle after pressed falls; no short_press.
//  5. Boundary: release debounced exactly in the terminal-count cycle.
//     -> short_press=1, long_press=0, signal stays 1.
//  6. Reset during LONG_HELD: resetn pulse low 1 cycle.
//     -> signal=1 immediately.
//     -> with pin still low, long_press recurs after 10+64 cycles.

Source files
------------

// File: rtl/button_press_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_press_decoder_pkg
// Description : Shared definitions for the push-button front end: FSM state
//               encodings and default timing constants.
//               Contents:
//                 state_t            - 2-bit FSM state (IDLE/PRESSED/LONG_HELD)
//                 c_DEBOUNCE_DEFAULT - log2 of debounce acceptance time
//                 c_LONG_DEFAULT     - log2 of long-press duration
// Revision    : 1.0 - initial release
// ============================================================================
package button_press_decoder_pkg;

  // Encoding 3 is unused; the FSM recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_t;

  // Defaults for the OSCH clock (~133 MHz): ~0.5 ms debounce, ~1 s long press.
  localparam int c_DEBOUNCE_DEFAULT = 16;
  localparam int c_LONG_DEFAULT     = 27;

endpackage : button_press_decoder_pkg
`default_nettype wire

// File: rtl/button_press_decoder_debounce_filter.sv
`default_nettype none
// ============================================================================
// Module      : debounce_filter
// Description : Two-flop synchroniser followed by a debounce counter for one
//               active-low pin. The synchronised pin must differ from the
//               accepted (stable) level for 2^DEBOUNCE consecutive cycles
//               before the stable level follows it; any return to the stable
//               level restarts the count. Pin-to-level latency is
//               2 + 2^DEBOUNCE cycles.
// Ports       :
//   clock      in  1  system clock
//   resetn     in  1  asynchronous active-low reset
//   signal_pin in  1  raw pin, asynchronous, low = asserted
//   level      out 1  debounced level, 1 = asserted (registered)
//   level_next out 1  value 'level' takes after the coming clock edge
// Parameters  :
//   DEBOUNCE   log2 of acceptance time in cycles (minimum 2)
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_filter
  import button_press_decoder_pkg::*;
#(
  parameter int DEBOUNCE = c_DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic signal_pin,
  output logic level,
  output logic level_next
);

  localparam logic [DEBOUNCE-1:0] c_CNT_ONE = {{(DEBOUNCE-1){1'b0}}, 1'b1};

  logic                r_sync1;
  logic                r_sync2;
  logic                r_stable;   // pin polarity: 1 = released
  logic [DEBOUNCE-1:0] r_count;

  logic                w_differs;
  logic                w_accept;

  // Plain flop chain, nothing between the stages.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= signal_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_differs = (r_sync2 != r_stable);
  assign w_accept  = w_differs && (&r_count);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stable <= 1'b1;
      r_count  <= '0;
    end else if (!w_differs) begin
      r_count  <= '0;
    end else if (w_accept) begin
      r_stable <= r_sync2;
      r_count  <= '0;
    end else begin
      r_count  <= r_count + c_CNT_ONE;
    end
  end

  assign level      = ~r_stable;
  // Lets a consumer register its reaction in the same edge the level flips.
  assign level_next = w_accept ? ~r_sync2 : ~r_stable;

endmodule : debounce_filter
`default_nettype wire

// File: rtl/button_press_decoder.sv
`default_nettype none
// ============================================================================
// Module      : button_press_decoder
// Description : Push-button front end. Debounces the raw active-low pin and
//               classifies each press as short or long, producing one-cycle
//               event pulses and an active-low reset request for the
//               application logic.
// Ports       :
//   clock       in  1  system clock (OSCH)
//   resetn      in  1  asynchronous active-low reset (power-on)
//   signal_pin  in  1  raw button pin, low = pressed
//   pressed     out 1  debounced level, 1 = pressed
//   short_press out 1  1-cycle pulse on release of a press < 2^LONG cycles
//   long_press  out 1  1-cycle pulse when a press reaches 2^LONG cycles
//   signal      out 1  active-low reset request, 0 while the press is held long
// Parameters  :
//   DEBOUNCE    log2 of debounce acceptance time (minimum 2)
//   LONG        log2 of long-press duration (minimum 2)
// Revision    : 1.0 - initial release
// ============================================================================
module button_press_decoder
  import button_press_decoder_pkg::*;
#(
  parameter int DEBOUNCE = c_DEBOUNCE_DEFAULT,
  parameter int LONG     = c_LONG_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic signal_pin,
  output logic pressed,
  output logic short_press,
  output logic long_press,
  output logic signal
);

  localparam logic [LONG-1:0] c_HOLD_ONE = {{(LONG-1){1'b0}}, 1'b1};

  logic            w_level;
  logic            w_level_next;

  state_t          r_state;
  state_t          w_next_state;
  logic [LONG-1:0] r_hold;
  logic [LONG-1:0] w_hold_next;
  logic            w_short;
  logic            w_long;

  logic            r_short;
  logic            r_long;
  logic            r_signal;

  debounce_filter #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clock      (clock),
    .resetn     (resetn),
    .signal_pin (signal_pin),
    .level      (w_level),
    .level_next (w_level_next)
  );

  // The FSM decides on the level the filter is about to adopt, so its
  // registered events land on the same edge the debounced level changes.
  always_comb begin
    w_next_state = r_state;
    w_hold_next  = r_hold;
    w_short      = 1'b0;
    w_long       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Edge, not level: a recovery into IDLE with the button down must
        // not be taken as a new press.
        if (w_level_next && !w_level) begin
          w_next_state = ST_PRESSED;
          w_hold_next  = '0;
        end
      end
      ST_PRESSED: begin
        // Release is tested first so it wins over the terminal count.
        if (!w_level_next) begin
          w_next_state = ST_IDLE;
          w_short      = 1'b1;
        end else if (&r_hold) begin
          w_next_state = ST_LONG_HELD;
          w_long       = 1'b1;
        end else begin
          w_hold_next  = r_hold + c_HOLD_ONE;
        end
      end
      ST_LONG_HELD: begin
        if (!w_level_next) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_next_state;
      r_hold  <= w_hold_next;
    end
  end

  // The reset request covers LONG_HELD plus the cycle in which the release
  // is taken, so it deasserts one cycle after 'pressed' falls.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_signal <= 1'b1;
    end else begin
      r_short  <= w_short;
      r_long   <= w_long;
      r_signal <= !((w_next_state == ST_LONG_HELD) || (r_state == ST_LONG_HELD));
    end
  end

  assign pressed     = w_level;
  assign short_press = r_short;
  assign long_press  = r_long;
  assign signal      = r_signal;

endmodule : button_press_decoder
`default_nettype wire
